branch_local_two_level: RTL and testbench



---
 rtl/branch_local_two_level.sv | 145 ++++++++++++++
 tb/tb_branch_local_two_level.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/branch_local_two_level.sv
// Two-level local-history branch predictor.
//
// Each local history register (BHT) is selected by PC bits [2 +: log2(BHT_ENTRIES)]. It then
// indexes a table of saturating counters (PHT). The MSB of the selected counter is the
// prediction. After reset a clear FSM writes one entry of each table per cycle. This
// initialises both tables without a wide reset fan-out.
//
// Optional feature: define BRANCH_LOCAL_BYPASS_EN so that an update in the same cycle as a
// prediction to the same BHT entry is forwarded combinationally into the prediction.
//
// Ports:
//   clk        clock
//   reset      asynchronous active-high reset; restarts the table clear
//   pred_pc    PC of the branch being predicted (fetch)
//   prediction 1 = taken; forced to 0 until ready
//   ready      1 = tables initialised, prediction valid
//   update_en  commit a resolved branch this cycle (ignored while clearing)
//   update_pc  PC of the resolved branch (execute)
//   update_val resolved direction, 1 = taken
module branch_local_two_level #(
  parameter int unsigned BHT_ENTRIES = 4,
  parameter int unsigned PHT_ENTRIES = 2048,
  parameter int unsigned CTR_BITS    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pred_pc,
  output logic        prediction,
  output logic        ready,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        update_val
);

  localparam int unsigned HIST_BITS = $clog2(PHT_ENTRIES);
  localparam int unsigned BIDX_BITS = $clog2(BHT_ENTRIES);
  localparam int unsigned CLR_N     = (BHT_ENTRIES > PHT_ENTRIES) ? BHT_ENTRIES : PHT_ENTRIES;
  localparam int unsigned CLR_BITS  = $clog2(CLR_N);

  localparam logic [CTR_BITS-1:0] CtrWeakNt = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CtrMax    = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CtrOne    = CTR_BITS'(1);

  typedef enum logic {StClear, StReady} state_e;

  state_e                state_q, state_d;
  logic [CLR_BITS-1:0]   clr_q, clr_d;

  logic [HIST_BITS-1:0]  bht_q [BHT_ENTRIES];
  logic [CTR_BITS-1:0]   pht_q [PHT_ENTRIES];

  logic [BIDX_BITS-1:0]  pred_idx, upd_idx;
  logic [HIST_BITS-1:0]  upd_hist, hist_new;
  logic [CTR_BITS-1:0]   upd_ctr, ctr_new, pred_ctr;
  logic                  upd_fire;

  logic                  bht_we, pht_we;
  logic [BIDX_BITS-1:0]  bht_waddr;
  logic [HIST_BITS-1:0]  bht_wdata, pht_waddr;
  logic [CTR_BITS-1:0]   pht_wdata;

  assign pred_idx = pred_pc[BIDX_BITS+1:2];
  assign upd_idx  = update_pc[BIDX_BITS+1:2];
  assign upd_hist = bht_q[upd_idx];
  assign upd_ctr  = pht_q[upd_hist];
  assign upd_fire = (state_q == StReady) && !reset && update_en;

  // Saturating counter step and history shift (newest outcome enters at the LSB).
  always_comb begin
    ctr_new = upd_ctr;
    if (update_val) begin
      if (upd_ctr != CtrMax) ctr_new = upd_ctr + CtrOne;
    end else begin
      if (upd_ctr != '0) ctr_new = upd_ctr - CtrOne;
    end
    hist_new = {upd_hist[HIST_BITS-2:0], update_val};
  end

  // Clear FSM and table write-port selection.
  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    bht_we    = 1'b0;
    pht_we    = 1'b0;
    bht_waddr = upd_idx;
    bht_wdata = hist_new;
    pht_waddr = upd_hist;
    pht_wdata = ctr_new;
    unique case (state_q)
      StClear: begin
        bht_we    = !reset && (32'(clr_q) < BHT_ENTRIES);
        pht_we    = !reset && (32'(clr_q) < PHT_ENTRIES);
        bht_waddr = clr_q[BIDX_BITS-1:0];
        bht_wdata = '0;
        pht_waddr = clr_q[HIST_BITS-1:0];
        pht_wdata = CtrWeakNt;
        clr_d     = clr_q + CLR_BITS'(1);
        if (clr_q == CLR_BITS'(CLR_N - 1)) begin
          state_d = StReady;
          clr_d   = '0;
        end
      end
      StReady: begin
        bht_we = upd_fire;
        pht_we = upd_fire;
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StClear;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  // Table storage carries no reset; the clear FSM initialises it.
  always_ff @(posedge clk) begin
    if (bht_we) bht_q[bht_waddr] <= bht_wdata;
    if (pht_we) pht_q[pht_waddr] <= pht_wdata;
  end

  always_comb begin
    pred_ctr = pht_q[bht_q[pred_idx]];
`ifdef BRANCH_LOCAL_BYPASS_EN
    // Forward the in-flight update: the new history picks the counter, and if that counter
    // is the one being written, its new value is used.
    if (upd_fire && (pred_idx == upd_idx)) begin
      if (hist_new == upd_hist) pred_ctr = ctr_new;
      else                      pred_ctr = pht_q[hist_new];
    end
`endif
    ready      = (state_q == StReady) && !reset;
    prediction = ready && pred_ctr[CTR_BITS-1];
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[31:BIDX_BITS+2], pred_pc[1:0],
                            update_pc[31:BIDX_BITS+2], update_pc[1:0]};

endmodule

// File: tb/tb_branch_local_two_level.sv
// Directed self-checking bench for branch_local_two_level with default parameters.
module tb_branch_local_two_level;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pred_pc;
  logic        prediction;
  logic        ready;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_local_two_level dut (
    .clk       (clk),
    .reset     (reset),
    .pred_pc   (pred_pc),
    .prediction(prediction),
    .ready     (ready),
    .update_en (update_en),
    .update_pc (update_pc),
    .update_val(update_val)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; returns at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic predict(input string tag, input logic [31:0] pc, input logic exp);
    pred_pc = pc;
    #1;
    chk(tag, {31'b0, prediction}, {31'b0, exp});
  endtask

  task automatic upd(input logic [31:0] pc, input logic val);
    update_en  = 1'b1;
    update_pc  = pc;
    update_val = val;
    tick();
    update_en  = 1'b0;
  endtask

  // Runs the 2048-cycle clear, counting cycles where ready or prediction is not 0.
  task automatic clear_run(input string tag, input logic upd_during);
    int bad = 0;
    update_en  = upd_during;
    update_pc  = 32'h104;
    update_val = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      #1;
      if (ready !== 1'b0 || prediction !== 1'b0) bad++;
      tick();
    end
    update_en = 1'b0;
    chk(tag, bad, 0);
    #1;
    chk({tag, "_ready"}, {31'b0, ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic exp_bp;

  initial begin
    reset      = 1'b1;
    update_en  = 1'b0;
    update_pc  = 32'h0;
    update_val = 1'b0;
    pred_pc    = 32'h100;
    tick();
    tick();
    #1;
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_pred", {31'b0, prediction}, 32'd0);
    reset = 1'b0;
    clear_run("clear1", 1'b0);
    predict("post_clear_100", 32'h100, 1'b0);

    // Eleven taken updates walk the history 0 -> 0x7FF, leaving PHT[0x7FF] untouched (=1).
    for (int i = 0; i < 11; i++) upd(32'h100, 1'b1);
    predict("taken11", 32'h100, 1'b0);
    upd(32'h100, 1'b1);
    predict("taken12", 32'h100, 1'b1);
    predict("alias_110", 32'h110, 1'b1);
    // History 0 points at PHT[0], which the first taken update raised to 2.
    predict("idx1_104", 32'h104, 1'b1);
    upd(32'h100, 1'b1);
    predict("taken13", 32'h100, 1'b1);
    upd(32'h100, 1'b1);
    predict("sat14", 32'h100, 1'b1);
    upd(32'h100, 1'b0);
    predict("nt_100", 32'h100, 1'b0);

    // Same-cycle not-taken at 0x104: BHT[1]=0, PHT[0] 2->1, history stays 0.
    pred_pc    = 32'h104;
    update_pc  = 32'h104;
    update_val = 1'b0;
    update_en  = 1'b1;
    #1;
`ifdef BRANCH_LOCAL_BYPASS_EN
    exp_bp = 1'b0;
`else
    exp_bp = 1'b1;
`endif
    chk("same_cyc_nt", {31'b0, prediction}, {31'b0, exp_bp});
    tick();
    update_en = 1'b0;
    predict("after_nt", 32'h104, 1'b0);

    // Same-cycle taken at 0x104: PHT[0] 1->2, history 0->1 selects PHT[1]=2.
    update_val = 1'b1;
    update_en  = 1'b1;
    #1;
`ifdef BRANCH_LOCAL_BYPASS_EN
    exp_bp = 1'b1;
`else
    exp_bp = 1'b0;
`endif
    chk("same_cyc_t", {31'b0, prediction}, {31'b0, exp_bp});
    tick();
    update_en = 1'b0;
    predict("after_t", 32'h104, 1'b1);
    tick();
    tick();
    predict("idle_hold", 32'h104, 1'b1);

    // Floor: three not-taken at 0x108 drive PHT[0] 2->1->0->0.
    for (int i = 0; i < 3; i++) upd(32'h108, 1'b0);
    predict("floor_108", 32'h108, 1'b0);

    // Asynchronous reset in READY, no clock edge in between.
    pred_pc = 32'h104;
    #1;
    chk("pre_rst_pred", {31'b0, prediction}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async_ready", {31'b0, ready}, 32'd0);
    chk("async_pred", {31'b0, prediction}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    clear_run("clear2", 1'b1);
    predict("wiped_100", 32'h100, 1'b0);
    predict("wiped_104", 32'h104, 1'b0);
    predict("wiped_108", 32'h108, 1'b0);
    predict("wiped_10c", 32'h10C, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
